mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit that produces the HI/LO pair for the single-cycle MIPS core. It sits beside the ALU, directly downstream of the register file read ports (rs, rt data). It feeds the write-back mux with `hi`/`lo` for mfhi/mflo. Each operation uses one shift-add or restoring-subtract step per cycle, and the core stalls on `busy`.

## Interface
- WIDTH, 32, operand width; hi/lo each WIDTH bits
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request strobe, sampled only in IDLE
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 ignored
- a  in  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
- b  in  WIDTH  rt operand (divisor / multiplier)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when hi/lo have been updated by mult/div
- div_by_zero  out  1  qualifies done; high when the completed div/divu had b == 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIXUP.
- **IDLE**
  - start with op 0–3 latches the operands and op.
  - For signed ops, operands are latched as magnitudes plus sign flags; the step counter loads WIDTH and the state goes to RUN.
  - start with op 4 (mthi) writes `hi <= a`; op 5 (mtlo) writes `lo <= a`. Both stay in IDLE with no busy and no done.
  - op 6–7: no effect.
- **RUN** (multiply)
  - 2·WIDTH-bit product register.
  - If the multiplier LSB is 1, add the multiplicand into the upper half, then shift the product right by 1.
- **RUN** (divide)
  - Restoring divide: shift the remainder:quotient pair left by 1.
  - If remainder ≥ divisor, subtract and set quotient LSB to 1.
- Counter decrements each RUN cycle; at 1 the state goes to FIXUP.
- **FIXUP**
  - Signed mult: negate the 2·WIDTH product if the operand signs differ.
  - Signed div: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo (mult: hi = upper half, lo = lower half; div: lo = quotient, hi = remainder).
  - Pulse done and return to IDLE.
- **Divide by zero**
  - The natural restoring result is kept: lo = all ones, hi = dividend (a).
  - Signed fixup is suppressed.
  - div_by_zero = 1 with done.
- **Signed overflow** (0x80000000 / −1): lo = 0x80000000, hi = 0. No flag.
- start while busy is ignored and the operands are not re-sampled.
- Arithmetic is modulo 2^WIDTH per half. Adder width is WIDTH+1 to keep the carry.

## Timing
- Reset (reset_n low at a clock edge): state IDLE, counter 0, busy 0, done 0, div_by_zero 0, hi 0, lo 0.
- Reset mid-operation aborts the operation; partial results are discarded.
- Start accepted at edge E0: busy is high from after E0.
- RUN occupies edges E1..E_WIDTH; FIXUP occurs at edge E_WIDTH+1.
- After edge E_WIDTH+1, busy falls, done is high for exactly one cycle, and hi/lo hold the new values in that same cycle.
- Total latency is WIDTH+2 edges (34 for WIDTH=32).
- A new start may be accepted in the cycle done is high; state is IDLE then.
- mthi/mtlo take effect on the accepting edge; the value is visible the next cycle.
- hi/lo are stable throughout RUN, so mfhi/mflo reads before done return the previous values.

## Configuration
- MULTDIV_DIV_EN defined: div/divu are supported as described.
- MULTDIV_DIV_EN undefined:
  - Divide datapath is removed; op 2/3 are treated like op 6–7 (no busy, no done, hi/lo unchanged).
  - div_by_zero is tied to 0.
  - mult/multu/mthi/mtlo are unaffected.

## Structure
- Shared package `mips_pkg`:
  - op encoding enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
  - state enum (IDLE, RUN, FIXUP)
  - default WIDTH constant
- One natural sub-module, `md_sign_fix`: combinational magnitude/negation helper. It is used both at operand latch and in FIXUP.

## Test plan
- **Reset:** reset_n low for 2 cycles, then release → hi=0, lo=0, busy=0, done=0, div_by_zero=0.
- **Multiply:**
  - mult a=0xFFFFFFFF, b=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE, done exactly 34 edges after start.
  - multu on the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- **Divide:**
  - div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=100, b=7 → lo=14, hi=2.
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- **Divide by zero:** divu a=5, b=0 → lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done; the next op clears div_by_zero.
- **Ignored start and abort:**
  - start multu 3×4 at cycle 5 of a running mult → ignored; the first result is unchanged.
  - reset_n low at RUN cycle 10 → busy=0, hi=lo=0, no done.
- **mthi/mtlo:** mthi 0x12345678 → hi=0x12345678 next cycle, busy never high. Repeat with MULTDIV_DIV_EN undefined: divu start → no busy, hi/lo unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide op encoding, unit state encoding and default width.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIXUP
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Core <-> multiply/divide unit signals; master is the core side, slave is the unit.
interface mult_div_unit_if
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation; yields a magnitude at operand latch and
// re-applies the sign to results in FIXUP.
module md_sign_fix #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] value,
    input  logic             neg,
    output logic [Width-1:0] result
);
    always_comb begin
        result = value;
        if (neg) begin
            result = ~value + 1'b1;
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Define MULTDIV_DIV_EN to build the divide datapath (div/divu); otherwise op 2/3 are ignored.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input logic            clk,
    input logic            reset_n,
    mult_div_unit_if.slave md
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    md_op_e             op;
    md_state_e          state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               op_signed, op_mul;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] prod_fix;

    assign op        = md_op_e'(md.op);
    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_mul    = (op == MD_MULT) || (op == MD_MULTU);

    md_sign_fix #(.Width(WIDTH)) u_fix_a (
        .value  (md.a),
        .neg    (op_signed & md.a[WIDTH-1]),
        .result (a_mag)
    );

    md_sign_fix #(.Width(WIDTH)) u_fix_b (
        .value  (md.b),
        .neg    (op_signed & md.b[WIDTH-1]),
        .result (b_mag)
    );

    // acc_q holds {partial product, remaining multiplier bits}; the carry enters the top bit.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    md_sign_fix #(.Width(2*WIDTH)) u_fix_prod (
        .value  (acc_q),
        .neg    (neg_q),
        .result (prod_fix)
    );

`ifdef MULTDIV_DIV_EN
    logic               div_q, div_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               op_div, b_zero;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic [2*WIDTH-1:0] div_step;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign op_div = (op == MD_DIV) || (op == MD_DIVU);
    assign b_zero = (md.b == '0);

    // acc_q holds {remainder, dividend/quotient}; a clear borrow bit means remainder >= divisor.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_sub  = rem_sh - {1'b0, opnd_q};
    assign div_step = rem_sub[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    md_sign_fix #(.Width(WIDTH)) u_fix_quot (
        .value  (acc_q[WIDTH-1:0]),
        .neg    (neg_q),
        .result (quot_fix)
    );

    md_sign_fix #(.Width(WIDTH)) u_fix_rem (
        .value  (acc_q[2*WIDTH-1:WIDTH]),
        .neg    (neg_rem_q),
        .result (rem_fix)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
`ifdef MULTDIV_DIV_EN
        div_d     = div_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (md.start) begin
                    if (op_mul) begin
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        neg_d   = op_signed & (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
                        cnt_d   = CntW'(WIDTH);
                        state_d = RUN;
`ifdef MULTDIV_DIV_EN
                        div_d   = 1'b0;
                    end else if (op_div) begin
                        // Divide by zero keeps the raw dividend so the remainder comes out as a.
                        acc_d     = {{WIDTH{1'b0}}, b_zero ? md.a : a_mag};
                        opnd_d    = b_mag;
                        neg_d     = op_signed & (md.a[WIDTH-1] ^ md.b[WIDTH-1]) & ~b_zero;
                        neg_rem_d = op_signed & md.a[WIDTH-1] & ~b_zero;
                        dz_d      = b_zero;
                        div_d     = 1'b1;
                        cnt_d     = CntW'(WIDTH);
                        state_d   = RUN;
`endif
                    end else if (op == MD_MTHI) begin
                        hi_d = md.a;
                    end else if (op == MD_MTLO) begin
                        lo_d = md.a;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = FIXUP;
                end
`ifdef MULTDIV_DIV_EN
                if (div_q) begin
                    acc_d = div_step;
                end else
`endif
                begin
                    acc_d = mul_step;
                end
            end
            FIXUP: begin
                state_d = IDLE;
                done_d  = 1'b1;
`ifdef MULTDIV_DIV_EN
                if (div_q) begin
                    lo_d  = quot_fix;
                    hi_d  = rem_fix;
                    dbz_d = dz_q;
                end else
`endif
                begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef MULTDIV_DIV_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end
`endif

    assign md.busy        = (state_q != IDLE);
    assign md.done        = done_q;
    assign md.div_by_zero = dbz_q;
    assign md.hi          = hi_q;
    assign md.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: 64-bit arithmetic reference model, randomized and
// directed ops; honours MULTDIV_DIV_EN the same way as the design.
module tb_mult_div_unit;

    typedef struct {
        int          due;
        logic        dbz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [31:0] model_hi = '0, model_lo = '0;
    logic [31:0] pend_hi = '0, pend_lo = '0;

    mult_div_unit_if #(.WIDTH(32)) md ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (md)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic bit is_long(input logic [2:0] op);
`ifdef MULTDIV_DIV_EN
        return op <= 3'd3;
`else
        return op <= 3'd1;
`endif
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.due = 0;
        e.dbz = 1'b0;
        e.hi  = '0;
        e.lo  = '0;
        case (op)
            3'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd1: begin u = {32'd0, a} * {32'd0, b}; e.hi = u[63:32]; e.lo = u[31:0]; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    e.dbz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else if (op == 3'd2) begin
                    p = sa / sb; e.lo = p[31:0];
                    p = sa % sb; e.hi = p[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (md.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (md.hi !== e.hi || md.lo !== e.lo || md.div_by_zero !== e.dbz) begin
                    errors++;
                    $display("FAIL result: hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b",
                             md.hi, md.lo, md.div_by_zero, e.hi, e.lo, e.dbz);
                end
                checks++;
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL latency: done at cycle %0d, required %0d", cyc, e.due);
                end
            end
        end else if (md.div_by_zero === 1'b1) begin
            checks++; errors++;
            $display("FAIL dbz_without_done: div_by_zero=1 with done=0, required 0");
        end
    end

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        md.start = 1'b1;
        md.op    = op;
        md.a     = a;
        md.b     = b;
        if (is_long(op)) begin
            e = model(op, a, b);
            e.due = cyc + 34;
            sb_q.push_back(e);
            pend_hi = e.hi;
            pend_lo = e.lo;
        end else if (op == 3'd4) begin
            model_hi = a;
        end else if (op == 3'd5) begin
            model_lo = a;
        end
        @(negedge clk);
        md.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (md.busy === 1'b1 && n < 60) begin
            if (n == 10) begin
                check32("hi_stable_in_run", md.hi, model_hi);
                check32("lo_stable_in_run", md.lo, model_lo);
            end
            @(negedge clk);
            n++;
        end
        if (md.busy !== 1'b0) begin
            checks++; errors++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", md.busy, n);
        end
        model_hi = pend_hi;
        model_lo = pend_lo;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_op(op, a, b);
        if (is_long(op)) begin
            check1("busy_after_start", md.busy, 1'b1);
            wait_idle();
        end else begin
            check1("busy_short_op", md.busy, 1'b0);
            check32("hi_short_op", md.hi, model_hi);
            check32("lo_short_op", md.lo, model_lo);
        end
    endtask

    initial begin
        md.start = 1'b0;
        md.op    = '0;
        md.a     = '0;
        md.b     = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check32("reset_hi", md.hi, 32'h0);
        check32("reset_lo", md.lo, 32'h0);
        check1("reset_busy", md.busy, 1'b0);
        check1("reset_done", md.done, 1'b0);
        check1("reset_dbz", md.div_by_zero, 1'b0);

        run_op(3'd0, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
`ifdef MULTDIV_DIV_EN
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd3, 32'd100, 32'd7);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd5, 32'd0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0);
        run_op(3'd1, 32'd6, 32'd7);
`else
        run_op(3'd3, 32'd100, 32'd7);
        run_op(3'd2, 32'd5, 32'd0);
`endif
        run_op(3'd4, 32'h1234_5678, 32'd0);
        run_op(3'd5, 32'hCAFE_F00D, 32'd0);
        run_op(3'd6, 32'hDEAD_BEEF, 32'd1);

        // A second start while busy must not disturb the running multiply.
        start_op(3'd0, 32'h0001_0003, 32'hFFFF_FFFB);
        repeat (4) @(negedge clk);
        md.start = 1'b1; md.op = 3'd1; md.a = 32'd3; md.b = 32'd4;
        @(negedge clk);
        md.start = 1'b0;
        wait_idle();

        // Reset mid-run: no done may follow and hi/lo return to zero.
        start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        sb_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        check1("abort_busy", md.busy, 1'b0);
        check32("abort_hi", md.hi, 32'h0);
        check32("abort_lo", md.lo, 32'h0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick());
        end

        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: %0d results outstanding, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
